// File: rtl/conv_accel_system.sv
// conv_accel_system
//   Streaming 2D convolution engine built around a single multiply-accumulate.
//   For every output element (y outer, x, ch inner) it pulls K*K*CI taps, one
//   activation and one weight per tap, over two independent valid/ready
//   channels. The host supplies every tap, including padding taps, which it
//   marks with a zero flag. It then emits the wrapped accumulator with its
//   coordinates.
//
// Ports
//   clk            rising-edge clock
//   arst_n_in      synchronous reset, active-high (name kept for host compatibility)
//   a_input/a_valid/a_ready/a_zero_flag   activation tap channel
//   b_input/b_valid/b_ready/b_zero_flag   weight tap channel
//   start          launches a layer when idle
//   running        high while a layer is in progress
//   out/output_valid/output_x/output_y/output_ch   one result per pulse
module conv_accel_system #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int EXT_MEM_HEIGHT     = 256,
    parameter int EXT_MEM_WIDTH      = 32,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 16,
    parameter int KERNEL_SIZE        = 3
) (
    input  logic                                   clk,
    input  logic                                   arst_n_in,
    input  logic signed [IO_DATA_WIDTH-1:0]        a_input,
    input  logic                                   a_valid,
    output logic                                   a_ready,
    input  logic                                   a_zero_flag,
    input  logic signed [IO_DATA_WIDTH-1:0]        b_input,
    input  logic                                   b_valid,
    output logic                                   b_ready,
    input  logic                                   b_zero_flag,
    input  logic                                   start,
    output logic                                   running,
    output logic signed [IO_DATA_WIDTH-1:0]        out,
    output logic                                   output_valid,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]   output_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]  output_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]  output_ch
);
    localparam int XW = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW = $clog2(OUTPUT_NB_CHANNELS);
    localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int IW = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;

    // The kernel must have a centre tap; the external-memory geometry is
    // reserved for a memory model and only sanity-checked here.
    if ((KERNEL_SIZE % 2) == 0 || EXT_MEM_HEIGHT < 1 || EXT_MEM_WIDTH < 1) begin : g_bad_params
        $error("conv_accel_system: KERNEL_SIZE must be odd and memory geometry positive");
    end

    typedef enum logic [1:0] {IDLE, FETCH, MAC, EMIT} state_t;

    state_t                               state_q, state_d;
    logic                                 running_q, running_d;
    logic                                 a_held_q, a_held_d;
    logic                                 b_held_q, b_held_d;
    logic [KW-1:0]                        ky_q, ky_d, kx_q, kx_d;
    logic [IW-1:0]                        ci_q, ci_d;
    logic [XW-1:0]                        x_q, x_d;
    logic [YW-1:0]                        y_q, y_d;
    logic [CW-1:0]                        ch_q, ch_d;
    logic signed [ACCUMULATION_WIDTH-1:0] acc_q, acc_d, acc_sum;
    logic signed [IO_DATA_WIDTH-1:0]      out_q, out_d;
    logic                                 ovalid_q, ovalid_d;
    logic [XW-1:0]                        ox_q, ox_d;
    logic [YW-1:0]                        oy_q, oy_d;
    logic [CW-1:0]                        och_q, och_d;

    // Captured tap operands; plain data, loaded only on a transfer.
    logic signed [IO_DATA_WIDTH-1:0]      a_q, b_q;
    logic                                 a_zf_q, b_zf_q;

    logic a_fire, b_fire;
    logic last_ci, last_kx, last_ky, last_tap;
    logic last_ch, last_x, last_y;

    function automatic logic signed [ACCUMULATION_WIDTH-1:0] mac_product(
        input logic signed [IO_DATA_WIDTH-1:0] a,
        input logic                            a_zero,
        input logic signed [IO_DATA_WIDTH-1:0] b,
        input logic                            b_zero
    );
        logic signed [2*IO_DATA_WIDTH-1:0] p;
        p = a * b;
        if (a_zero || b_zero) return '0;
        return ACCUMULATION_WIDTH'(p);
    endfunction

    // Result is the low bits of the accumulator: wrap, never saturate.
    function automatic logic signed [IO_DATA_WIDTH-1:0] wrap_out(
        input logic signed [ACCUMULATION_WIDTH-1:0] acc
    );
        return acc[IO_DATA_WIDTH-1:0];
    endfunction

    assign a_ready  = (state_q == FETCH) && !a_held_q;
    assign b_ready  = (state_q == FETCH) && !b_held_q;
    assign a_fire   = a_valid && a_ready;
    assign b_fire   = b_valid && b_ready;

    assign last_ci  = (ci_q == IW'(INPUT_NB_CHANNELS - 1));
    assign last_kx  = (kx_q == KW'(KERNEL_SIZE - 1));
    assign last_ky  = (ky_q == KW'(KERNEL_SIZE - 1));
    assign last_tap = last_ci && last_kx && last_ky;
    assign last_ch  = (ch_q == CW'(OUTPUT_NB_CHANNELS - 1));
    assign last_x   = (x_q == XW'(FEATURE_MAP_WIDTH - 1));
    assign last_y   = (y_q == YW'(FEATURE_MAP_HEIGHT - 1));

    assign acc_sum  = acc_q + mac_product(a_q, a_zf_q, b_q, b_zf_q);

    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        a_held_d  = a_held_q;
        b_held_d  = b_held_q;
        ky_d      = ky_q;
        kx_d      = kx_q;
        ci_d      = ci_q;
        x_d       = x_q;
        y_d       = y_q;
        ch_d      = ch_q;
        acc_d     = acc_q;
        out_d     = out_q;
        ovalid_d  = 1'b0;
        ox_d      = ox_q;
        oy_d      = oy_q;
        och_d     = och_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    running_d = 1'b1;
                    a_held_d  = 1'b0;
                    b_held_d  = 1'b0;
                    ky_d      = '0;
                    kx_d      = '0;
                    ci_d      = '0;
                    x_d       = '0;
                    y_d       = '0;
                    ch_d      = '0;
                    acc_d     = '0;
                end
            end
            FETCH: begin
                if (a_fire) a_held_d = 1'b1;
                if (b_fire) b_held_d = 1'b1;
                // Counting a same-cycle transfer lets a tap take only FETCH+MAC.
                if ((a_held_q || a_fire) && (b_held_q || b_fire)) state_d = MAC;
            end
            MAC: begin
                acc_d    = acc_sum;
                a_held_d = 1'b0;
                b_held_d = 1'b0;
                if (!last_ci) begin
                    ci_d = ci_q + 1'b1;
                end else begin
                    ci_d = '0;
                    if (!last_kx) begin
                        kx_d = kx_q + 1'b1;
                    end else begin
                        kx_d = '0;
                        ky_d = last_ky ? '0 : ky_q + 1'b1;
                    end
                end
                if (last_tap) begin
                    // Result registers load here so they are valid during EMIT
                    // and keep their value after the accumulator clears.
                    state_d  = EMIT;
                    out_d    = wrap_out(acc_sum);
                    ovalid_d = 1'b1;
                    ox_d     = x_q;
                    oy_d     = y_q;
                    och_d    = ch_q;
                end else begin
                    state_d = FETCH;
                end
            end
            EMIT: begin
                acc_d = '0;
                if (!last_ch) begin
                    ch_d = ch_q + 1'b1;
                end else begin
                    ch_d = '0;
                    if (!last_x) begin
                        x_d = x_q + 1'b1;
                    end else begin
                        x_d = '0;
                        y_d = last_y ? '0 : y_q + 1'b1;
                    end
                end
                if (last_ch && last_x && last_y) begin
                    state_d   = IDLE;
                    running_d = 1'b0;
                end else begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_fire) begin
            a_q    <= a_input;
            a_zf_q <= a_zero_flag;
        end
        if (b_fire) begin
            b_q    <= b_input;
            b_zf_q <= b_zero_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n_in) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            a_held_q  <= 1'b0;
            b_held_q  <= 1'b0;
            ky_q      <= '0;
            kx_q      <= '0;
            ci_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ch_q      <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            ovalid_q  <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
            och_q     <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            a_held_q  <= a_held_d;
            b_held_q  <= b_held_d;
            ky_q      <= ky_d;
            kx_q      <= kx_d;
            ci_q      <= ci_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ch_q      <= ch_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            ovalid_q  <= ovalid_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            och_q     <= och_d;
        end
    end

    assign running      = running_q;
    assign out          = out_q;
    assign output_valid = ovalid_q;
    assign output_x     = ox_q;
    assign output_y     = oy_q;
    assign output_ch    = och_q;

endmodule

// File: tb/tb_conv_accel_system.sv
module tb_conv_accel_system;
    localparam int TAPS = 18;  // 3x3 kernel, 2 input channels

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n_in;
    logic [15:0] a_input, b_input;
    logic        a_valid, a_ready, a_zero_flag;
    logic        b_valid, b_ready, b_zero_flag;
    logic        start, running, output_valid;
    logic [15:0] out;
    logic [0:0]  output_x, output_y, output_ch;

    conv_accel_system #(
        .IO_DATA_WIDTH(16), .ACCUMULATION_WIDTH(32),
        .EXT_MEM_HEIGHT(256), .EXT_MEM_WIDTH(32),
        .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
        .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(3)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready), .a_zero_flag(a_zero_flag),
        .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready), .b_zero_flag(b_zero_flag),
        .start(start), .running(running),
        .out(out), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
    );

    typedef struct {
        logic signed [15:0] a;       // activation of tap 0
        logic signed [15:0] a_step;  // activation increment per tap
        logic signed [15:0] b;       // weight on every tap
        logic [17:0]        az_mask; // per-tap a_zero_flag
        logic [17:0]        bz_mask; // per-tap b_zero_flag
        bit                 skew;    // b 4 cycles behind a, random gaps, a held
        logic [15:0]        exp_out;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int fails  = 0;
    int a_xfers = 0;
    int b_xfers = 0;
    logic [15:0] res_out[$];
    logic [2:0]  res_yxc[$];
    logic        res_run[$];

    always @(negedge clk) begin
        if (a_valid && a_ready) a_xfers++;
        if (b_valid && b_ready) b_xfers++;
        if (output_valid) begin
            res_out.push_back(out);
            res_yxc.push_back({output_y, output_x, output_ch});
            res_run.push_back(running);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_tap(input logic [15:0] a, input logic az,
                            input logic [15:0] b, input logic bz, input bit skew);
        int a_gap, b_gap, cyc;
        bit a_done, b_done, af, bf;
        a_gap  = skew ? int'($urandom_range(0, 3)) : 0;
        b_gap  = skew ? a_gap + 4 : 0;
        a_done = 0;
        b_done = 0;
        cyc    = 0;
        a_input = a; a_zero_flag = az;
        b_input = b; b_zero_flag = bz;
        while (!(a_done && b_done) && cyc < 64) begin
            a_valid = (cyc >= a_gap) && (!a_done || skew);
            b_valid = (cyc >= b_gap) && !b_done;
            af = a_valid && a_ready && !a_done;
            bf = b_valid && b_ready;
            @(posedge clk); #1;
            if (af) a_done = 1;
            if (bf) b_done = 1;
            cyc++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("tap_handshake_done", {31'd0, a_done && b_done}, 32'd1);
    endtask

    task automatic wait_result(input int idx, output bit got);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (res_out.size() > idx) got = 1;
            else begin
                @(negedge clk); #1;
            end
        end
    endtask

    initial begin
        bit got;
        int a0, b0;

        // a, a_step, b, az_mask, bz_mask, skew, expected out
        vecs[0] = '{16'sd1,     16'sd0, 16'sd1,     18'h0,     18'h0,     1'b0, 16'h0012}; // 18*1
        vecs[1] = '{-16'sd3,    16'sd0, 16'sd5,     18'h0,     18'h0,     1'b0, 16'hFEF2}; // -270
        vecs[2] = '{16'sd300,   16'sd0, 16'sd300,   18'h0,     18'h0,     1'b0, 16'hB820}; // 1,620,000 = 0x18B820
        vecs[3] = '{16'sd7,     16'sd0, 16'sd7,     18'h001FF, 18'h00E00, 1'b0, 16'h0126}; // 6*49 = 294
        vecs[4] = '{16'sd2,     16'sd0, -16'sd4,    18'h0,     18'h0,     1'b1, 16'hFF70}; // -144, skewed
        vecs[5] = '{16'sd2,     16'sd0, -16'sd4,    18'h0,     18'h0,     1'b0, 16'hFF70}; // same, gap-free
        vecs[6] = '{-16'sd5,    16'sd1, 16'sd3,     18'h0,     18'h0,     1'b0, 16'h00BD}; // 3*(-5..12) = 189
        vecs[7] = '{16'sd1000,  16'sd0, -16'sd1000, 18'h20000, 18'h0,     1'b1, 16'h99C0}; // -17,000,000

        arst_n_in = 1'b1;
        start = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_input = '0; b_input = '0; a_zero_flag = 1'b0; b_zero_flag = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_running", {31'd0, running}, 32'd0);
        chk("reset_a_ready", {31'd0, a_ready}, 32'd0);
        chk("reset_b_ready", {31'd0, b_ready}, 32'd0);
        chk("reset_output_valid", {31'd0, output_valid}, 32'd0);
        chk("reset_out", {16'd0, out}, 32'd0);
        chk("reset_coords", {29'd0, output_y, output_x, output_ch}, 32'd0);
        arst_n_in = 1'b0;
        @(posedge clk); #1;
        chk("idle_without_start", {31'd0, running}, 32'd0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_running", {31'd0, running}, 32'd1);
        chk("start_a_ready", {31'd0, a_ready}, 32'd1);
        chk("start_b_ready", {31'd0, b_ready}, 32'd1);

        for (int v = 0; v < 8; v++) begin
            a0 = a_xfers;
            b0 = b_xfers;
            if (v == 3) start = 1'b1;  // ignored while running
            for (int t = 0; t < TAPS; t++)
                send_tap(16'(vecs[v].a + vecs[v].a_step * t), vecs[v].az_mask[t],
                         vecs[v].b, vecs[v].bz_mask[t], vecs[v].skew);
            start = 1'b0;
            wait_result(v, got);
            chk("result_arrives", {31'd0, got}, 32'd1);
            if (got) begin
                chk("result_out", {16'd0, res_out[v]}, {16'd0, vecs[v].exp_out});
                chk("result_yxc", {29'd0, res_yxc[v]}, 32'(v));
                chk("result_running", {31'd0, res_run[v]}, 32'd1);
                chk("a_consumed_once", 32'(a_xfers - a0), 32'(TAPS));
                chk("b_consumed_once", 32'(b_xfers - b0), 32'(TAPS));
            end
        end

        // The cycle after the last result: layer over, result held.
        @(posedge clk); #1;
        chk("layer_end_running", {31'd0, running}, 32'd0);
        chk("layer_end_a_ready", {31'd0, a_ready}, 32'd0);
        chk("layer_end_output_valid", {31'd0, output_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("out_holds", {16'd0, out}, 32'h99C0);
        chk("coords_hold", {29'd0, output_y, output_x, output_ch}, 32'd7);
        chk("result_count", 32'(res_out.size()), 32'd8);

        // Relaunch, then reset in the middle of the first output.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("relaunch_running", {31'd0, running}, 32'd1);
        for (int t = 0; t < 3; t++) send_tap(16'd5, 1'b0, 16'd5, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("in_fetch_before_reset", {31'd0, a_ready}, 32'd1);
        arst_n_in = 1'b1;
        @(posedge clk); #1;
        arst_n_in = 1'b0;
        chk("midreset_running", {31'd0, running}, 32'd0);
        chk("midreset_a_ready", {31'd0, a_ready}, 32'd0);
        chk("midreset_b_ready", {31'd0, b_ready}, 32'd0);
        chk("midreset_output_valid", {31'd0, output_valid}, 32'd0);
        chk("midreset_out", {16'd0, out}, 32'd0);
        chk("midreset_coords", {29'd0, output_y, output_x, output_ch}, 32'd0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < TAPS; t++) send_tap(16'd1, 1'b0, 16'd1, 1'b0, 1'b0);
        wait_result(8, got);
        chk("restart_result_arrives", {31'd0, got}, 32'd1);
        if (got) begin
            chk("restart_out", {16'd0, res_out[8]}, 32'd18);
            chk("restart_yxc", {29'd0, res_yxc[8]}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
